obi_dma_copy: RTL and testbench

OBI_DMA_COPY -- requirements
Module: obi_dma_copy

---
 rtl/obi_dma_copy.sv | 171 +++++++++++++++++
 tb/tb_obi_dma_copy.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_dma_copy.sv
// rtl/obi_dma_copy.sv - single-outstanding OBI word copy engine (read word, write word, repeat)
// Both source and destination windows are range-checked against the SRAM before any bus traffic.
module obi_dma_copy #(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
  parameter int          LEN_W          = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  output logic [31:0]      wdata_o,
  input  logic             rvalid_i,
  input  logic [31:0]      rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH
  } state_e;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  // 33-bit end addresses so a window wrapping past 2^32 can never look legal
  logic [32:0] len_bytes;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        range_ok;
  logic        abort_pend;

  always_comb begin
    len_bytes  = 33'(cnt_q) << 2;
    src_end    = {1'b0, src_q} + len_bytes;
    dst_end    = {1'b0, dst_q} + len_bytes;
    range_ok   = (src_q >= SRAM_BASE_ADDR) && (src_end <= {1'b0, SRAM_END_ADDR}) &&
                 (dst_q >= SRAM_BASE_ADDR) && (dst_end <= {1'b0, SRAM_END_ADDR});
    abort_pend = abort_q | abort_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    abort_d = abort_q;
    if ((state_q != S_IDLE) && abort_i) begin
      abort_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & 32'hFFFF_FFFC;
          dst_d   = dst_addr_i & 32'hFFFF_FFFC;
          cnt_d   = len_i;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!range_ok) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // an abort still lets the read complete, but the word is never written
        if (rvalid_i) begin
          data_d  = rdata_i;
          state_d = abort_pend ? S_FINISH : S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (gnt_i) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (rvalid_i) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ((cnt_q == CNT_ONE) || abort_pend) ? S_FINISH : S_RD_REQ;
        end
      end
      S_FINISH: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_FINISH);
    err_o   = err_q;
    req_o   = 1'b0;
    we_o    = 1'b0;
    be_o    = 4'h0;
    addr_o  = '0;
    wdata_o = '0;
    case (state_q)
      S_RD_REQ: begin
        req_o  = 1'b1;
        be_o   = 4'hF;
        addr_o = src_q;
      end
      S_WR_REQ: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'hF;
        addr_o  = dst_q;
        wdata_o = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_obi_dma_copy.sv
// tb/tb_obi_dma_copy.sv - randomized bench for obi_dma_copy with an SRAM responder and transaction-list model
module tb_obi_dma_copy;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] END_A     = 32'h8000_C000;
  localparam int          LEN_W     = 14;
  localparam int          MEM_WORDS = 12288;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             start_i, abort_i;
  logic [31:0]      src_addr_i, dst_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o, done_o, err_o;
  logic             req_o, gnt_i, we_o, rvalid_i;
  logic [31:0]      addr_o, wdata_o, rdata_i;
  logic [3:0]       be_o;

  obi_dma_copy #(.SRAM_BASE_ADDR(BASE), .SRAM_END_ADDR(END_A), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] model_mem [MEM_WORDS];
  txn_t        log_q[$];
  txn_t        exp_q[$];

  int          gnt_min = 0, gnt_max = 0, rv_max = 0, abort_word = -1, rd_cnt = 0;
  int          gnt_wait = 0, resp_dly = 0;
  bit          in_req = 0, resp_pend = 0;
  logic [31:0] resp_data, req_addr_s, req_wdata_s;
  logic        req_we_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_sram(input logic [31:0] a);
    return (a >= BASE) && (a < END_A);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // OBI slave: random grant latency, response at least one cycle after the grant
  initial begin
    txn_t t;
    gnt_i = 0; rvalid_i = 0; rdata_i = '0; abort_i = 0;
    forever begin
      @(negedge clk);
      abort_i = 0;
      if (!rst_ni) begin
        gnt_i = 0; rvalid_i = 0; rdata_i = '0; resp_pend = 0; in_req = 0;
      end else begin
        if (gnt_i) begin
          t.we = req_we_s; t.addr = req_addr_s; t.wdata = req_wdata_s;
          log_q.push_back(t);
          check("one_outstanding", resp_pend, 0);
          resp_data = 32'hDEAD_BEEF;
          if (in_sram(t.addr)) begin
            if (t.we) mem[widx(t.addr)] = t.wdata;
            else resp_data = mem[widx(t.addr)];
          end
          resp_pend = 1;
          resp_dly  = $urandom_range(0, rv_max);
          if (!t.we) begin
            if (rd_cnt == abort_word) abort_i = 1;
            rd_cnt++;
          end
          in_req = 0;
        end
        gnt_i = 0; rvalid_i = 0; rdata_i = '0;
        if (resp_pend) begin
          if (resp_dly == 0) begin
            rvalid_i = 1; rdata_i = resp_data; resp_pend = 0;
          end else resp_dly--;
        end
        if (req_o) begin
          if (!in_req) begin
            in_req = 1;
            gnt_wait = $urandom_range(gnt_min, gnt_max);
            req_addr_s = addr_o; req_we_s = we_o; req_wdata_s = wdata_o;
            check("be_full", be_o, 4'hF);
          end else begin
            check("req_stable", {addr_o, we_o, be_o, wdata_o}, {req_addr_s, req_we_s, 4'hF, req_wdata_s});
          end
          if (gnt_wait == 0) gnt_i = 1;
          else gnt_wait--;
        end else begin
          check("req_withdrawn", in_req, 0);
          in_req = 0;
          check("idle_zero", {addr_o, we_o, be_o, wdata_o}, 0);
        end
      end
    end
  end

  task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] dst,
                         input int len, input int abort_w, input int gmin, input int gmax, input int rvm);
    logic [31:0] s, d, data;
    bit          legal;
    int          cyc, done_cnt, done_at, n;
    txn_t        t;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    legal = (s >= BASE) && (longint'(s) + 4 * len <= longint'(END_A)) &&
            (d >= BASE) && (longint'(d) + 4 * len <= longint'(END_A));
    exp_q.delete();
    if (legal) begin
      for (int i = 0; i < len; i++) begin
        data = model_mem[widx(s + 32'(4 * i))];
        t.we = 0; t.addr = s + 32'(4 * i); t.wdata = '0;
        exp_q.push_back(t);
        if (i == abort_w) break;
        t.we = 1; t.addr = d + 32'(4 * i); t.wdata = data;
        exp_q.push_back(t);
        model_mem[widx(d + 32'(4 * i))] = data;
      end
    end
    gnt_min = gmin; gnt_max = gmax; rv_max = rvm; abort_word = abort_w; rd_cnt = 0;
    log_q.delete();
    @(negedge clk);
    start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = LEN_W'(len);
    cyc = 0; done_cnt = 0; done_at = -1;
    while (cyc < 5000 && (done_at < 0 || cyc < done_at + 3)) begin
      @(negedge clk);
      cyc++;
      start_i = 0;
      if (cyc == 1) check({name, "_busy"}, busy_o, 1);
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_err"}, err_o, !legal);
    check({name, "_busy_after"}, busy_o, 0);
    if (!legal || len == 0) check({name, "_done_at"}, done_at, 2);
    check({name, "_txn_count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_txn_we"}, log_q[i].we, exp_q[i].we);
      check({name, "_txn_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check({name, "_txn_wdata"}, log_q[i].wdata, exp_q[i].wdata);
    end
    if (legal) begin
      for (int i = 0; i < len; i++)
        check({name, "_dst_mem"}, mem[widx(d + 32'(4 * i))], model_mem[widx(d + 32'(4 * i))]);
    end
  endtask

  task automatic reset_mid_write();
    int cyc;
    gnt_min = 3; gnt_max = 3; rv_max = 0; abort_word = -1; rd_cnt = 0;
    @(negedge clk);
    start_i = 1; src_addr_i = BASE + 32'h200; dst_addr_i = BASE + 32'h6000; len_i = LEN_W'(4);
    @(negedge clk);
    start_i = 0;
    cyc = 0;
    while (cyc < 200 && !(req_o && we_o)) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_wr_req", req_o && we_o, 1);
    rst_ni = 0;
    @(negedge clk);
    check("rst_req", req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk);
    rst_ni = 1;
  endtask

  initial begin
    logic [31:0] s, d;
    int          len, ab;
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s, d;
    int          len, ab;
    rst_ni = 0; start_i = 0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, err_o, req_o, we_o, be_o, addr_o, wdata_o}, 0);
    rst_ni = 1;

    run_job("basic",       32'h8000_0000, 32'h8000_1000, 3,  -1, 0, 0, 0);
    run_job("slow_gnt",    32'h8000_0100, 32'h8000_2001, 4,  -1, 3, 3, 1);
    run_job("dst_over",    32'h8000_0000, 32'h8000_BFFC, 2,  -1, 0, 0, 0);
    run_job("len_zero",    32'h8000_0040, 32'h8000_3000, 0,  -1, 0, 0, 0);
    run_job("abort_w2",    32'h8000_0400, 32'h8000_4000, 5,   1, 0, 2, 2);
    run_job("src_below",   32'h7FFF_FFFC, 32'h8000_4000, 1,  -1, 0, 0, 0);
    run_job("wrap",        32'hFFFF_FFF0, 32'h8000_4000, 8,  -1, 0, 0, 0);
    run_job("exact_fit",   32'h8000_0800, 32'h8000_BFF8, 2,  -1, 1, 2, 1);
    reset_mid_write();
    run_job("after_reset", 32'h8000_0200, 32'h8000_6000, 4,  -1, 0, 1, 1);

    for (int j = 0; j < 10; j++) begin
      len = $urandom_range(1, 40);
      s   = BASE + 32'(4 * $urandom_range(0, 2000)) + 32'($urandom_range(0, 3));
      d   = BASE + 32'(4 * $urandom_range(6000, 8000)) + 32'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_job("random", s, d, len, ab, 0, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
